flex_down_counter: RTL
======================

# flex_down_counter

Parameterised, loadable down-counter/timer that complements the team's flex up-counter. It captures a start value, decrements on each enabled cycle, and reports terminal count. It supports one-shot and auto-reload modes. Protocol blocks use it for countdown timeouts, bit-period timers and byte/word countdowns where the up-counter's compare-to-rollover model is awkward.

## Interface
- NUM_CNT_BITS, 4, width of the counter, the load value and the reload register (≥2)
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk
- clear  input  1  synchronous abort: zero the counter and return to idle
- load  input  1  start/restart: capture load_val
- count_enable  input  1  decrement qualifier while running
- auto_reload  input  1  1 = reload on terminal count and keep running; 0 = one-shot
- load_val  input  NUM_CNT_BITS  start value, unsigned
- count_out  output  NUM_CNT_BITS  current count (registered)
- busy  output  1  high in RUN state (registered)
- done  output  1  one-cycle pulse on terminal count (registered)
- expired  output  1  sticky one-shot completion flag, high in DONE state (registered)

## Operation
- Internal state: 2-bit FSM {IDLE, RUN, DONE}, plus reload_reg[NUM_CNT_BITS].
- Priority per edge: rst > clear > load > count_enable.
- rst: state IDLE, count_out 0, reload_reg 0, busy 0, done 0, expired 0.
- clear (any state): state IDLE, count_out 0, reload_reg 0, done 0. load and count_enable are ignored that cycle.
- load (any state, clear low):
  - count_out and reload_reg take load_val.
  - If load_val ≠ 0: state RUN.
  - If load_val = 0: state DONE, done pulses, expired set.
  - load in RUN restarts the count; any pending terminal event is discarded.
- IDLE/DONE: count_enable is ignored and count_out holds.
- RUN, count_enable=1:
  - count_out > 1: count_out - 1.
  - count_out = 1 (terminal), done = 1 next cycle.
    - auto_reload=1: count_out takes reload_reg and the state stays RUN.
    - auto_reload=0: count_out becomes 0 and the state becomes DONE.
- RUN, count_enable=0: count_out holds.
- auto_reload is sampled at the terminal edge only. Changing it mid-count has no other effect.
- reload_reg = 1 with auto_reload: count_out stays 1 and done pulses on every enabled cycle.
- Arithmetic is unsigned. The counter never underflows: the minimum in RUN is 1, and 0 appears only in IDLE/DONE.
- busy = (state == RUN). expired = (state == DONE). Both are driven from registered state.

## Timing
- Load latency: load high at edge k → count_out = load_val and busy = 1 after edge k.
- Count duration: with count_enable held high from edge k+1, one-shot reaches count_out = 0 after load_val enabled edges, i.e. after edge k+load_val.
  - done = 1, expired = 1 and busy = 0 in that same cycle.
  - done drops after the next edge.
- Auto-reload period: done pulses every reload_reg enabled cycles. A gated count_enable stretches the period; cycles are not counted.
- done is never high for two consecutive cycles, except when reload_reg = 1 with count_enable held high.
- rst or clear mid-count: outputs take their reset values at that edge and no done pulse follows.
- Simultaneous load and terminal edge: load wins, count_out = load_val and no done pulse.

## Test plan
- Reset, then load_val=5 with count_enable=1 continuous, auto_reload=0 → count_out 5,4,3,2,1,0; done high one cycle with count_out=0; expired stays 1; busy 0.
- load_val=3 with auto_reload=1 and enable continuous for 10 cycles → count_out 3,2,1,3,2,1,3,…; done pulses at each 1→3 transition (every 3 cycles); expired stays 0.
- load_val=4 with count_enable toggling 1,0,1,0… → count_out decrements only on enabled edges; done arrives 8 cycles after load.
- load_val=0 → next cycle: expired=1, done pulse, busy=0, count_out=0. Then count_enable pulses → no change.
- Mid-count events from load_val=9:
  - At count 6, assert clear → count_out 0, IDLE, no done.
  - Reload 9; at count 1, assert load with load_val=2 on the terminal edge → count_out 2, no done.
  - Assert rst → all outputs 0.
- NUM_CNT_BITS=4, load_val=15, auto_reload=0 → 15 enabled cycles to 0, no wrap to 15 afterwards.

Source files
------------

// File: rtl/flex_down_counter_if.sv
// Control/status bundle for flex_down_counter.
// master = block driving the timer, slave = the timer itself.
interface flex_down_counter_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic                    count_enable;
  logic                    auto_reload;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    busy;
  logic                    done;
  logic                    expired;

  modport master (
    output clear, load, count_enable, auto_reload, load_val,
    input  count_out, busy, done, expired
  );

  modport slave (
    input  clear, load, count_enable, auto_reload, load_val,
    output count_out, busy, done, expired
  );
endinterface

// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with terminal-count pulse, one-shot and auto-reload modes.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | after reset/clear; count_out 0, enable ignored
//   RUN   | counting down on enabled edges; count_out is never below 1
//   DONE  | one-shot finished (or zero load); expired high, count holds
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  flex_down_counter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
  logic                    done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (bus.clear) begin
      state_d  = IDLE;
      count_d  = CNT_ZERO;
      reload_d = CNT_ZERO;
    end else if (bus.load) begin
      // A load overrides any terminal event on the same edge.
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      if (bus.load_val == CNT_ZERO) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN && bus.count_enable) begin
      if (count_q == CNT_ONE) begin
        done_d = 1'b1;
        if (bus.auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = CNT_ZERO;
          state_d = DONE;
        end
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  assign bus.count_out = count_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.expired   = (state_q == DONE);

endmodule
